score_counter: RTL and testbench

//  Producer side of the score path. It counts game scoring events and holds the current

---
 rtl/score_counter.sv | 59 +++++
 tb/tb_score_counter.sv | 115 +++++++++++
 2 files changed

// File: rtl/score_counter.sv
// score_counter: counts score events, keeping binary and BCD forms in lockstep, plus session high score.
module score_counter #(
  parameter int MAX_SCORE = 99,
  parameter bit WRAP      = 1'b0,
  parameter int SCORE_W   = 7
) (
  input  logic               i_Clk,
  input  logic               i_Rst_n,
  input  logic               i_Inc,
  input  logic               i_Clear,
  output logic [SCORE_W-1:0] o_Score,
  output logic [3:0]         o_Tens,
  output logic [3:0]         o_Ones,
  output logic [SCORE_W-1:0] o_High,
  output logic               o_Updated,
  output logic               o_Wrap,
  output logic               o_AtMax
);
  logic               inc_d;
  logic               inc_evt;
  logic               step;
  logic               roll;
  logic               zero;
  logic               upd;
  logic [SCORE_W-1:0] next_score;
  logic [3:0]         next_tens;
  logic [3:0]         next_ones;
  assign inc_evt = i_Inc & ~inc_d;
  assign o_AtMax = o_Score == SCORE_W'(MAX_SCORE);
  assign step    = inc_evt & ~i_Clear & ~o_AtMax;
  assign roll    = inc_evt & ~i_Clear & o_AtMax & WRAP;
  assign zero    = i_Clear | roll;
  assign upd     = i_Clear ? |o_Score : step | roll;
  // digits advance as counters; ones 9->0 carries into tens
  always_comb begin
    next_score = zero ? '0 : step ? o_Score + 1'b1 : o_Score;
    next_ones  = zero ? 4'd0 : step ? (o_Ones == 4'd9 ? 4'd0 : o_Ones + 4'd1) : o_Ones;
    next_tens  = zero ? 4'd0 : (step && o_Ones == 4'd9) ? o_Tens + 4'd1 : o_Tens;
  end
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      inc_d     <= 1'b0;
      o_Score   <= '0;
      o_Tens    <= 4'd0;
      o_Ones    <= 4'd0;
      o_High    <= '0;
      o_Updated <= 1'b0;
      o_Wrap    <= 1'b0;
    end else begin
      inc_d     <= i_Inc;
      o_Score   <= next_score;
      o_Tens    <= next_tens;
      o_Ones    <= next_ones;
      o_Updated <= upd;
      o_Wrap    <= roll;
      if (next_score > o_High) o_High <= next_score;
    end
  end
endmodule

// File: tb/tb_score_counter.sv
// tb_score_counter: directed checks of score_counter in saturating and wrapping builds driven in parallel.
module tb_score_counter;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       inc = 1'b0;
  logic       clear = 1'b0;
  logic [6:0] s0, h0, s1, h1;
  logic [3:0] t0, o0, t1, o1;
  logic       u0, w0, m0, u1, w1, m1;
  int         n_chk = 0;
  int         n_fail = 0;

  always #5 clk = ~clk;

  score_counter #(.MAX_SCORE(99), .WRAP(1'b0), .SCORE_W(7)) d0 (
    .i_Clk(clk), .i_Rst_n(rst_n), .i_Inc(inc), .i_Clear(clear),
    .o_Score(s0), .o_Tens(t0), .o_Ones(o0), .o_High(h0),
    .o_Updated(u0), .o_Wrap(w0), .o_AtMax(m0)
  );
  score_counter #(.MAX_SCORE(99), .WRAP(1'b1), .SCORE_W(7)) d1 (
    .i_Clk(clk), .i_Rst_n(rst_n), .i_Inc(inc), .i_Clear(clear),
    .o_Score(s1), .o_Tens(t1), .o_Ones(o1), .o_High(h1),
    .o_Updated(u1), .o_Wrap(w1), .o_AtMax(m1)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic pulse();
    @(negedge clk) inc = 1'b1;
    @(negedge clk) inc = 1'b0;
  endtask

  task automatic clr();
    @(negedge clk) clear = 1'b1;
    @(negedge clk) clear = 1'b0;
  endtask

  initial begin
    // T1: reset held while i_Inc toggles
    repeat (4) @(negedge clk) inc = ~inc;
    chk("rst_score", s0, 0); chk("rst_tens", t0, 0); chk("rst_ones", o0, 0);
    chk("rst_high", h0, 0); chk("rst_upd", u0, 0); chk("rst_wrap", w1, 0);
    chk("rst_atmax", m0, 0); chk("rst_score_w", s1, 0);
    @(negedge clk) begin inc = 1'b0; rst_n = 1'b1; end
    pulse();
    chk("t1_score", s0, 1); chk("t1_tens", t0, 0); chk("t1_ones", o0, 1);
    chk("t1_upd", u0, 1); chk("t1_score_w", s1, 1);
    @(negedge clk);
    chk("t1_upd_drop", u0, 0);
    // T2: level held counts once
    clr();
    chk("t2_clr", s0, 0);
    @(negedge clk) inc = 1'b1;
    repeat (20) @(negedge clk);
    inc = 1'b0;
    chk("t2_hold", s0, 1);
    repeat (9) pulse();
    chk("t2_score", s0, 10); chk("t2_tens", t0, 1); chk("t2_ones", o0, 0);
    chk("t2_high", h0, 10);
    // T5: clear keeps the high score
    clr();
    repeat (37) pulse();
    chk("t5_score", s0, 37); chk("t5_tens", t0, 3); chk("t5_ones", o0, 7);
    clr();
    chk("t5_clr_score", s0, 0); chk("t5_clr_upd", u0, 1);
    chk("t5_high", h0, 37); chk("t5_high_w", h1, 37);
    clr();
    chk("t5_clr_zero_upd", u0, 0);
    repeat (5) pulse();
    chk("t5_score5", s0, 5); chk("t5_high_keep", h0, 37);
    @(negedge clk) begin clear = 1'b1; inc = 1'b1; end
    @(negedge clk) clear = 1'b0;
    chk("t5_both_score", s0, 0); chk("t5_both_upd", u0, 1);
    @(negedge clk);
    chk("t5_consumed", s0, 0); chk("t5_consumed_upd", u0, 0);
    inc = 1'b0;
    // T3/T4: saturate vs wrap
    repeat (99) pulse();
    chk("t3_score", s0, 99); chk("t3_tens", t0, 9); chk("t3_ones", o0, 9);
    chk("t3_atmax", m0, 1); chk("t4_atmax", m1, 1); chk("t3_high", h0, 99);
    pulse();
    chk("t3_sat_score", s0, 99); chk("t3_sat_upd", u0, 0); chk("t3_sat_wrap", w0, 0);
    chk("t4_wrap_score", s1, 0); chk("t4_wrap_upd", u1, 1); chk("t4_wrap", w1, 1);
    chk("t4_atmax0", m1, 0); chk("t4_high", h1, 99);
    chk("t4_tens", t1, 0); chk("t4_ones", o1, 0);
    @(negedge clk);
    chk("t4_wrap_drop", w1, 0);
    for (int i = 0; i < 5; i++) begin
      pulse();
      chk("t3_sat_upd_n", u0, 0);
      chk("t3_sat_wrap_n", w0, 0);
    end
    chk("t3_sat_final", s0, 99); chk("t4_after", s1, 5); chk("t4_after_ones", o1, 5);
    // T6: asynchronous reset between edges
    clr();
    repeat (42) pulse();
    chk("t6_score", s0, 42); chk("t6_tens", t0, 4); chk("t6_ones", o0, 2);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_score", s0, 0); chk("t6_async_high", h0, 0);
    chk("t6_async_tens", t0, 0); chk("t6_async_ones", o0, 0);
    chk("t6_async_score_w", s1, 0); chk("t6_async_high_w", h1, 0);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    chk("t6_post", s0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
